irq_pending_ctrl_8: RTL and testbench
=====================================

# irq_pending_ctrl_8

Eight-line interrupt front end that sits directly upstream of the 8-input one-hot priority circuit. It captures rising edges on raw request lines into sticky pending bits, applies a software-writable mask, and drives the masked vector into the priority circuit. It then takes the one-hot winner back, encodes it to a 3-bit id, and presents it to the consumer under a valid/ack handshake. A pending bit clears only when its grant is acknowledged.

## Interface
- `DEFAULT_MASK`, 8'hFF: mask value loaded at reset; 1 = line enabled.
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: synchronous, active-high reset.
- `irq_in`, in, 8: raw request lines, level-valued.
- `mask_wr`, in, 1: mask write strobe.
- `mask_din`, in, 8: new mask, loaded when `mask_wr`=1.
- `req_o`, out, 8: `pending & mask`; drives the priority circuit's `i` input.
- `h_in`, in, 8: one-hot grant from the priority circuit, with bit 7 highest priority.
- `idle_in`, in, 1: priority circuit idle, meaning `req_o`==0.
- `pend_o`, out, 8: raw pending register, unmasked.
- `irq_valid`, out, 1: grant presented.
- `irq_id`, out, 3: binary index of the granted line; stable while `irq_valid`=1.
- `irq_ack`, in, 1: consumer accepts the grant.

## Operation
- Edge capture: `irq_q` is the registered copy of the sampled `irq_in`. `rise = irq_s & ~irq_q`. A set `rise[k]` sets `pending[k]` at the clock edge.
- `irq_q` resets to 0, so a line already high when reset is released counts as one rising edge.
- Mask gates `req_o` only and never clears `pending`. A masked line keeps accumulating. Unmasking it later exposes the pending bit immediately.
- `req_o` is combinational from the `pending` and `mask` registers.
- FSM state IDLE:
  - When `idle_in`=0, latch `irq_id = encode(h_in)`, go to SERVE and assert `irq_valid`.
  - When `idle_in`=1, stay in IDLE.
- FSM state SERVE:
  - Hold `irq_id` and `irq_valid`; `h_in`, `mask` and new edges do not affect them.
  - On `irq_ack`=1, clear `pending[irq_id]`, deassert `irq_valid` and return to IDLE.
- Same-cycle clear and set on the same bit: set wins and the bit stays pending, because the new edge is a new event.
- Masking the served line during SERVE does not retract the grant.
- `irq_ack` while in IDLE is ignored.
- `mask_wr` takes effect at the next edge. Mask writes and `pending` updates in the same cycle are independent.
- Encoding assumes `h_in` is one-hot whenever `idle_in`=0. A non-one-hot `h_in` is a priority-circuit fault, and the result is unspecified.

## Timing
- Reset values:
  - `pending`=0, `irq_q`=0, `mask`=`DEFAULT_MASK`, FSM=IDLE.
  - Outputs: `req_o`=0, `pend_o`=0, `irq_valid`=0, `irq_id`=0.
- Edge capture: `irq_in` rises before edge N. `pending` and `req_o` update after edge N, and the priority circuit resolves in the same cycle.
- Grant: the grant is latched at edge N+1 and `irq_valid`=1 after edge N+1. Latency from request to valid is 2 edges, or 4 with `IRQ_SYNC_EN`.
- Ack: `irq_ack` is sampled at edge M while `irq_valid`=1. `irq_valid`=0 and `pending` is cleared after edge M. The earliest next `irq_valid` is after edge M+1, so there is one mandatory low cycle between grants.
- Reset mid-SERVE: the grant is dropped and all pending bits are lost.

## Configuration
- `IRQ_SYNC_EN` defined: `irq_in` passes through a 2-flop synchronizer (reset 0) before `irq_q` and edge detection, giving `irq_s` = synchronizer output. This adds 2 cycles to the request-to-pending latency.
- `IRQ_SYNC_EN` undefined: `irq_s = irq_in`, sampled directly. The inputs must then be synchronous to `clk`.

## Test plan
- **Reset and single request:** hold `rst` 2 cycles, then pulse `irq_in`=8'h08. Expect `pend_o`=8'h08, then `irq_valid`=1 with `irq_id`=3 two edges after the rise. Assert `irq_ack` and expect `pend_o`=0 and `irq_valid`=0.
- **Priority order:** raise `irq_in`=8'h81 in one cycle. Expect `irq_id`=7 first, then after ack `irq_id`=0, then idle with `pend_o`=0.
- **Mask:** write `mask_din`=8'h7F, then raise bit 7. Expect `req_o`=0, `pend_o`=8'h80 and no valid. Write 8'hFF and expect a grant with `irq_id`=7.
- **Set-wins race:** with line 2 in SERVE, produce a new rise on line 2 in the same cycle as `irq_ack`. Expect `pend_o[2]`=1 and a re-grant of `irq_id`=2 after the 1-cycle gap.
- **Hold stability:** during SERVE with `irq_id`=1, raise line 6. Expect `irq_id` to stay 1 until ack, then `irq_id`=6.
- **Reset mid-SERVE:** assert `rst` with `irq_valid`=1. Expect all outputs at reset values after the edge. With `IRQ_SYNC_EN` defined, also check the 4-edge latency in the single-request scenario.

Source files
------------

// File: rtl/irq_pending_ctrl_8.sv
// irq_pending_ctrl_8
//   Eight-line interrupt front end placed upstream of an 8-input one-hot
//   priority circuit. Rising edges on irq_in set sticky pending bits, a
//   software mask gates which pending bits are offered to the priority
//   circuit, and the one-hot winner returned on h_in is encoded and held for
//   the consumer under a valid/ack handshake. A pending bit is cleared only
//   when its grant is acknowledged.
//
//   Optional build macro: IRQ_SYNC_EN
//     defined   - irq_in passes through a 2-flop synchronizer before edge
//                 detection (request-to-valid latency of 4 edges).
//     undefined - irq_in is sampled directly and must be synchronous to clk
//                 (request-to-valid latency of 2 edges).
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset
//     irq_in     in   [7:0] raw level-valued request lines
//     mask_wr    in   mask write strobe
//     mask_din   in   [7:0] new mask value (1 = line enabled)
//     req_o      out  [7:0] pending & mask, to the priority circuit
//     h_in       in   [7:0] one-hot grant from the priority circuit (bit 7 highest)
//     idle_in    in   priority circuit idle (req_o == 0)
//     pend_o     out  [7:0] raw pending register
//     irq_valid  out  grant presented to the consumer
//     irq_id     out  [2:0] index of the granted line, stable while irq_valid
//     irq_ack    in   consumer accepts the grant
module irq_pending_ctrl_8 #(
  parameter logic [7:0] DEFAULT_MASK = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_din,
  output logic [7:0] req_o,
  input  logic [7:0] h_in,
  input  logic       idle_in,
  output logic [7:0] pend_o,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  input  logic       irq_ack
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] irq_s;
  logic [7:0] irq_q;
  logic [7:0] rise;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] id_q, id_d;
  logic [7:0] clr;

  // One-hot to binary. Each id bit is the OR of the one-hot lines whose
  // index has that bit set; a non-one-hot input gives an unspecified id.
  function automatic logic [2:0] encode(input logic [7:0] oh);
    logic [2:0] id;
    id[0] = oh[1] | oh[3] | oh[5] | oh[7];
    id[1] = oh[2] | oh[3] | oh[6] | oh[7];
    id[2] = oh[4] | oh[5] | oh[6] | oh[7];
    return id;
  endfunction

`ifdef IRQ_SYNC_EN
  // Input synchronizer stage
  logic [7:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // Edge detection stage. irq_q resets to 0 so a line that is already high
  // when reset is released is seen as one rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 8'h00;
    end else begin
      irq_q <= irq_s;
    end
  end

  assign rise = irq_s & ~irq_q;

  // Grant FSM, pending clear and mask next-state
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    clr     = 8'h00;
    case (state_q)
      IDLE: begin
        if (!idle_in) begin
          id_d    = encode(h_in);
          state_d = SERVE;
        end
      end
      SERVE: begin
        // irq_id is held here regardless of h_in, mask or new edges.
        if (irq_ack) begin
          clr     = 8'h01 << id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new edge on the line being acknowledged is a new event, so the set
    // is applied after the clear and wins.
    pend_d = (pend_q & ~clr) | rise;
    mask_d = mask_wr ? mask_din : mask_q;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 3'd0;
      pend_q  <= 8'h00;
      mask_q  <= DEFAULT_MASK;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
    end
  end

  // The mask only gates what is offered downstream; pending keeps
  // accumulating on masked lines.
  assign req_o     = pend_q & mask_q;
  assign pend_o    = pend_q;
  assign irq_valid = (state_q == SERVE);
  assign irq_id    = id_q;

endmodule

// File: tb/tb_irq_pending_ctrl_8.sv
module tb_irq_pending_ctrl_8;

`ifdef IRQ_SYNC_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_in;
  logic       mask_wr;
  logic [7:0] mask_din;
  logic [7:0] req_o;
  logic [7:0] h_in;
  logic       idle_in;
  logic [7:0] pend_o;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ack;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  irq_pending_ctrl_8 #(.DEFAULT_MASK(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .mask_wr   (mask_wr),
    .mask_din  (mask_din),
    .req_o     (req_o),
    .h_in      (h_in),
    .idle_in   (idle_in),
    .pend_o    (pend_o),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack)
  );

  // Stand-in for the downstream priority circuit: highest set bit wins.
  always_comb begin
    h_in = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (req_o[k]) h_in = 8'h01 << k;
    end
  end
  assign idle_in = (req_o == 8'h00);

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: a set of pending lines, a mask, and "currently serving
  // line X or nothing". Each clock: acknowledged line leaves the set, new
  // edges join it, and an idle server picks the highest enabled pending line.
  bit [7:0] m_pend, m_mask, m_prev, m_s1, m_s2;
  bit       m_srv, m_rst;
  int       m_id;
  int       exp_q[$];

  function automatic int highest(input bit [7:0] v);
    int r = -1;
    for (int k = 0; k < 8; k++) if (v[k]) r = k;
    return r;
  endfunction

  always @(posedge clk) begin
    bit [7:0] s;
    bit [7:0] nxt;
    m_rst <= rst;
    if (rst) begin
      m_pend <= 8'h00;
      m_mask <= 8'hFF;
      m_prev <= 8'h00;
      m_s1   <= 8'h00;
      m_s2   <= 8'h00;
      m_srv  <= 1'b0;
      m_id   <= 0;
      exp_q.delete();
    end else begin
`ifdef IRQ_SYNC_EN
      s = m_s2;
`else
      s = irq_in;
`endif
      nxt = m_pend;
      if (m_srv) begin
        if (irq_ack) begin
          nxt[m_id] = 1'b0;
          m_srv <= 1'b0;
        end
      end else if ((m_pend & m_mask) != 8'h00) begin
        m_id  <= highest(m_pend & m_mask);
        m_srv <= 1'b1;
        exp_q.push_back(highest(m_pend & m_mask));
      end
      for (int k = 0; k < 8; k++) if (s[k] && !m_prev[k]) nxt[k] = 1'b1;
      m_pend <= nxt;
      m_prev <= s;
      m_s1   <= irq_in;
      m_s2   <= m_s1;
      if (mask_wr) m_mask <= mask_din;
    end
  end

  // ---------------- monitor ----------------
  logic prev_v = 1'b0;
  int   held_id = 0;

  always @(posedge clk) begin
    #2;
    chk("pend_o", int'(pend_o), int'(m_pend));
    chk("req_o", int'(req_o), int'(m_pend & m_mask));
    chk("irq_valid", int'(irq_valid), int'(m_srv));
    if (m_rst) chk("irq_id_reset", int'(irq_id), 0);
    if (irq_valid === 1'b1) begin
      if (!prev_v) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", int'(irq_id), -1);
        end else begin
          chk("irq_id", int'(irq_id), exp_q.pop_front());
        end
        held_id = int'(irq_id);
      end else begin
        chk("irq_id_hold", int'(irq_id), held_id);
      end
    end
    prev_v = (irq_valid === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (irq_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_valid", int'(irq_valid === 1'b1), 1);
  endtask

  task automatic ack_one();
    wait_valid();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  initial begin
    int lat;
    rst      = 1'b1;
    irq_in   = 8'h00;
    mask_wr  = 1'b0;
    mask_din = 8'h00;
    irq_ack  = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // single request with latency measurement
    irq_in = 8'h08;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) irq_in = 8'h00;
    end while (irq_valid !== 1'b1 && lat < 10);
    chk("latency", lat, EXP_LAT);
    @(negedge clk);
    ack_one();
    idle(2);

    // priority order
    irq_in = 8'h81;
    idle(1);
    irq_in = 8'h00;
    ack_one();
    ack_one();
    idle(3);

    // mask
    mask_wr = 1'b1; mask_din = 8'h7F;
    idle(1);
    mask_wr = 1'b0;
    irq_in = 8'h80;
    idle(1);
    irq_in = 8'h00;
    idle(6);
    mask_wr = 1'b1; mask_din = 8'hFF;
    idle(1);
    mask_wr = 1'b0;
    ack_one();
    idle(2);

    // set-wins race on line 2
    irq_in = 8'h04;
    wait_valid();
    irq_in = 8'h00;
    idle(1);
    irq_in  = 8'h04;
    irq_ack = 1'b1;
    idle(1);
    irq_ack = 1'b0;
    ack_one();
    irq_in = 8'h00;
    idle(4);

    // hold stability
    irq_in = 8'h02;
    idle(1);
    irq_in = 8'h00;
    wait_valid();
    irq_in = 8'h40;
    idle(1);
    irq_in = 8'h00;
    idle(5);
    ack_one();
    ack_one();
    idle(2);

    // reset while serving
    irq_in = 8'h10;
    idle(1);
    irq_in = 8'h00;
    wait_valid();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      irq_in   = 8'($urandom);
      irq_ack  = (irq_valid === 1'b1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mask_wr  = ($urandom_range(0, 9) == 0);
      mask_din = 8'($urandom);
      rst      = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0; irq_ack = 1'b0; mask_wr = 1'b0; irq_in = 8'h00;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
